// File: rtl/mu_fifo_burst_reader.sv
// FIFO read-port consumer: pops words, absorbs read latency in a credit-controlled
// 2-entry buffer, and tags fixed-length bursts with first/last markers.
module mu_fifo_burst_reader #(
  parameter int unsigned DW         = 32,
  parameter int unsigned BURST_LEN  = 16,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned FCW        = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [DW-1:0]  fifo_dout,
  input  logic           fifo_valid,
  output logic           fifo_ready,
  input  logic           enable,
  input  logic           flush,
  output logic [DW-1:0]  m_data,
  output logic           m_valid,
  input  logic           m_ready,
  output logic           m_first,
  output logic           m_last,
  output logic [FCW-1:0] burst_count,
  output logic           busy
);

  localparam int unsigned   IW       = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(BURST_LEN - 1);
  localparam bit            LAT1     = (RD_LATENCY != 0);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, FLUSH} state_t;

  state_t        state;
  logic [1:0]    occ;
  logic          inflight;
  logic          keep;
  logic          keep_first;
  logic          keep_last;
  logic [IW-1:0] idx;
  logic [DW-1:0] slot1_data;
  logic          slot1_first;
  logic          slot1_last;

  logic          fire;
  logic          pop;
  logic          take;
  logic          hold;
  logic          space;
  logic          cur_first;
  logic          cur_last;
  logic          wr;
  logic          wr_first;
  logic          wr_last;
  logic [DW-1:0] wr_data;
  logic [1:0]    occ_nxt;
  logic [IW-1:0] idx_nxt;

  assign m_valid   = (occ != 2'd0);
  assign fire      = m_valid & m_ready;
  assign hold      = ~enable & (idx == '0);
  assign cur_first = (idx == '0);
  assign cur_last  = (idx == LAST_IDX);
  assign idx_nxt   = cur_last ? '0 : idx + IW'(1);
  assign busy      = (state != IDLE) | m_valid | inflight;

  // Credit: buffered words plus the captured pop still in flight, net of this cycle's fire.
  assign space = (({1'b0, occ} + {2'b00, keep}) - {2'b00, fire}) < 3'd2;

  always_comb begin
    fifo_ready = 1'b0;
    case (state)
      STREAM:  fifo_ready = space & ~hold;
      FLUSH:   fifo_ready = 1'b1;
      default: fifo_ready = 1'b0;
    endcase
  end

  assign pop  = fifo_valid & fifo_ready;
  assign take = pop & (state == STREAM) & ~flush;

  always_comb begin
    wr_data = fifo_dout;
    if (LAT1) begin
      wr       = keep;
      wr_first = keep_first;
      wr_last  = keep_last;
    end else begin
      wr       = take;
      wr_first = cur_first;
      wr_last  = cur_last;
    end
  end

  always_comb begin
    occ_nxt = occ;
    if (wr & ~fire)
      occ_nxt = occ + 2'd1;
    else if (~wr & fire)
      occ_nxt = occ - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      occ         <= '0;
      inflight    <= 1'b0;
      keep        <= 1'b0;
      keep_first  <= 1'b0;
      keep_last   <= 1'b0;
      idx         <= '0;
      m_data      <= '0;
      m_first     <= 1'b0;
      m_last      <= 1'b0;
      slot1_data  <= '0;
      slot1_first <= 1'b0;
      slot1_last  <= 1'b0;
      burst_count <= '0;
    end else begin
      if (fire & m_last)
        burst_count <= burst_count + FCW'(1);
      inflight   <= LAT1 & pop;
      keep_first <= cur_first;
      keep_last  <= cur_last;

      if (flush && state != FLUSH) begin
        // A pop or capture landing in this cycle is dropped along with the buffer.
        state <= FLUSH;
        occ   <= '0;
        keep  <= 1'b0;
        idx   <= '0;
      end else begin
        keep <= LAT1 & take;
        occ  <= occ_nxt;
        if (take)
          idx <= idx_nxt;

        case (occ)
          2'd0: begin
            if (wr) begin
              m_data  <= wr_data;
              m_first <= wr_first;
              m_last  <= wr_last;
            end
          end
          2'd1: begin
            if (wr & fire) begin
              m_data  <= wr_data;
              m_first <= wr_first;
              m_last  <= wr_last;
            end else if (wr) begin
              slot1_data  <= wr_data;
              slot1_first <= wr_first;
              slot1_last  <= wr_last;
            end
          end
          default: begin
            if (fire) begin
              m_data  <= slot1_data;
              m_first <= slot1_first;
              m_last  <= slot1_last;
            end
            if (wr) begin
              slot1_data  <= wr_data;
              slot1_first <= wr_first;
              slot1_last  <= wr_last;
            end
          end
        endcase

        case (state)
          IDLE: begin
            if (enable)
              state <= STREAM;
          end
          STREAM: begin
            if (hold)
              state <= IDLE;
            else if (take & cur_last & ~enable)
              state <= DRAIN;
          end
          DRAIN: begin
            if (occ_nxt == 2'd0)
              state <= IDLE;
          end
          FLUSH: begin
            if (~fifo_valid & ~inflight)
              state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mu_fifo_burst_reader.sv
// Directed bench for mu_fifo_burst_reader: a latency-1 instance with 4-word bursts
// and a latency-0 instance with single-word bursts, each fed by a behavioural FIFO.
module tb_mu_fifo_burst_reader;

  localparam int unsigned DW  = 32;
  localparam int unsigned FCW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  // Instance A: BURST_LEN=4, RD_LATENCY=1
  logic [DW-1:0]  a_dout = '0;
  logic [DW-1:0]  a_mdata;
  logic           a_fvalid, a_fready, a_enable, a_flush;
  logic           a_mvalid, a_mready, a_first, a_last, a_busy;
  logic [FCW-1:0] a_bcount;
  logic [DW-1:0]  a_mem [0:63];
  int unsigned    a_wp = 0;
  int unsigned    a_rp = 0;

  assign a_fvalid = (a_rp != a_wp);
  always @(posedge clk)
    if (a_fvalid && a_fready) begin
      a_dout <= a_mem[6'(a_rp)];
      a_rp   <= a_rp + 1;
    end

  mu_fifo_burst_reader #(.DW(DW), .BURST_LEN(4), .RD_LATENCY(1), .FCW(FCW)) dut_a (
    .clk(clk), .rst(rst),
    .fifo_dout(a_dout), .fifo_valid(a_fvalid), .fifo_ready(a_fready),
    .enable(a_enable), .flush(a_flush),
    .m_data(a_mdata), .m_valid(a_mvalid), .m_ready(a_mready),
    .m_first(a_first), .m_last(a_last),
    .burst_count(a_bcount), .busy(a_busy)
  );

  // Instance B: BURST_LEN=1, RD_LATENCY=0
  logic [DW-1:0]  b_dout;
  logic [DW-1:0]  b_mdata;
  logic           b_fvalid, b_fready, b_enable, b_flush;
  logic           b_mvalid, b_mready, b_first, b_last, b_busy;
  logic [FCW-1:0] b_bcount;
  logic [DW-1:0]  b_mem [0:63];
  int unsigned    b_wp = 0;
  int unsigned    b_rp = 0;

  assign b_fvalid = (b_rp != b_wp);
  assign b_dout   = b_mem[6'(b_rp)];
  always @(posedge clk)
    if (b_fvalid && b_fready)
      b_rp <= b_rp + 1;

  mu_fifo_burst_reader #(.DW(DW), .BURST_LEN(1), .RD_LATENCY(0), .FCW(FCW)) dut_b (
    .clk(clk), .rst(rst),
    .fifo_dout(b_dout), .fifo_valid(b_fvalid), .fifo_ready(b_fready),
    .enable(b_enable), .flush(b_flush),
    .m_data(b_mdata), .m_valid(b_mvalid), .m_ready(b_mready),
    .m_first(b_first), .m_last(b_last),
    .burst_count(b_bcount), .busy(b_busy)
  );

  // Monitors sample mid-cycle; inputs change just after the rising edge.
  int unsigned   a_pops = 0, a_fires = 0, a_stall_bad = 0;
  logic [DW+1:0] a_rec [0:63];
  int unsigned   a_fcyc [0:63];
  logic          a_pv = 1'b0, a_pr = 1'b0;
  logic [DW+1:0] a_ph = '0;
  always @(negedge clk) begin
    if (a_fvalid && a_fready)
      a_pops <= a_pops + 1;
    if (a_pv && !a_pr && !(a_mvalid && {a_mdata, a_first, a_last} == a_ph))
      a_stall_bad <= a_stall_bad + 1;
    if (a_mvalid && a_mready) begin
      a_rec[6'(a_fires)]  <= {a_mdata, a_first, a_last};
      a_fcyc[6'(a_fires)] <= cyc;
      a_fires             <= a_fires + 1;
    end
    a_pv <= a_mvalid;
    a_pr <= a_mready;
    a_ph <= {a_mdata, a_first, a_last};
  end

  int unsigned   b_fires = 0;
  logic [DW+1:0] b_rec [0:63];
  always @(negedge clk)
    if (b_mvalid && b_mready) begin
      b_rec[6'(b_fires)] <= {b_mdata, b_first, b_last};
      b_fires            <= b_fires + 1;
    end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_a(input logic [DW-1:0] v0, input int n);
    for (int i = 0; i < n; i++) begin
      a_mem[6'(a_wp)] = v0 + DW'(i);
      a_wp++;
    end
  endtask

  task automatic push_b(input logic [DW-1:0] v0, input int n);
    for (int i = 0; i < n; i++) begin
      b_mem[6'(b_wp)] = v0 + DW'(i);
      b_wp++;
    end
  endtask

  task automatic wait_a_fires(input int unsigned target, input string tag);
    for (int i = 0; i < 200 && a_fires < target; i++) step(1);
    chk(tag, 64'(a_fires >= target), 64'd1);
  endtask

  task automatic chk_a_rec(input int unsigned i, input logic [DW-1:0] d, input logic f, input logic l);
    logic [DW+1:0] r;
    r = a_rec[6'(i)];
    chk($sformatf("a_data[%0d]", i),  64'(r[DW+1:2]), 64'(d));
    chk($sformatf("a_first[%0d]", i), 64'(r[1]),      64'(f));
    chk($sformatf("a_last[%0d]", i),  64'(r[0]),      64'(l));
  endtask

  initial begin
    int unsigned   c0, bp, bf, outmax;
    logic          lastbusy;
    logic [DW+1:0] r;

    rst = 1'b1;
    a_enable = 1'b0; a_flush = 1'b0; a_mready = 1'b1;
    b_enable = 1'b0; b_flush = 1'b0; b_mready = 1'b1;
    step(3);
    rst = 1'b0;
    step(1);
    chk("rst_m_valid",     64'(a_mvalid), 64'd0);
    chk("rst_fifo_ready",  64'(a_fready), 64'd0);
    chk("rst_burst_count", 64'(a_bcount), 64'd0);
    chk("rst_busy",        64'(a_busy),   64'd0);
    chk("rst_m_data",      64'(a_mdata),  64'd0);
    chk("rst_m_first",     64'(a_first),  64'd0);
    chk("rst_m_last",      64'(a_last),   64'd0);
    chk("rst_b_m_valid",   64'(b_mvalid), 64'd0);

    // Two back-to-back bursts at full rate
    push_a(32'h10, 8);
    a_enable = 1'b1;
    c0 = cyc;
    wait_a_fires(8, "t1_wait");
    for (int unsigned i = 0; i < 8; i++) begin
      chk_a_rec(i, 32'h10 + DW'(i), (i % 4) == 0, (i % 4) == 3);
      chk($sformatf("t1_fire_cycle[%0d]", i), 64'(a_fcyc[6'(i)]), 64'(c0 + 3 + i));
    end
    chk("t1_burst_count", 64'(a_bcount), 64'd2);

    // Downstream stalls every other cycle
    outmax = 0;
    a_mready = 1'b0;
    push_a(32'h20, 8);
    for (int i = 0; i < 100 && a_fires < 16; i++) begin
      a_mready = ~a_mready;
      step(1);
      if (a_pops - a_fires > outmax) outmax = a_pops - a_fires;
    end
    chk("t2_wait", 64'(a_fires >= 16), 64'd1);
    for (int unsigned i = 0; i < 8; i++)
      chk_a_rec(8 + i, 32'h20 + DW'(i), (i % 4) == 0, (i % 4) == 3);
    chk("t2_burst_count",    64'(a_bcount),     64'd4);
    chk("t2_stall_stable",   64'(a_stall_bad),  64'd0);
    chk("t2_outstanding_le2", 64'(outmax <= 2), 64'd1);

    // enable drops after word 1 of a burst: the burst completes, nothing more is popped
    a_mready = 1'b1;
    bp = a_pops;
    bf = a_fires;
    push_a(32'h30, 8);
    for (int i = 0; i < 50 && a_pops < bp + 2; i++) step(1);
    a_enable = 1'b0;
    lastbusy = 1'b0;
    for (int i = 0; i < 50 && a_fires < bf + 4; i++) begin
      lastbusy = a_busy;
      step(1);
    end
    chk("t3_wait", 64'(a_fires >= bf + 4), 64'd1);
    chk("t3_busy_during_last_fire", 64'(lastbusy), 64'd1);
    chk("t3_busy_after_last_fire",  64'(a_busy),   64'd0);
    for (int unsigned i = 0; i < 4; i++)
      chk_a_rec(bf + i, 32'h30 + DW'(i), i == 0, i == 3);
    step(4);
    chk("t3_pops",        64'(a_pops - bp),  64'd4);
    chk("t3_fires",       64'(a_fires - bf), 64'd4);
    chk("t3_fifo_left",   64'(a_wp - a_rp),  64'd4);
    chk("t3_burst_count", 64'(a_bcount),     64'd5);

    // Flush with two words buffered and five left in the FIFO
    a_mready = 1'b0;
    push_a(32'h40, 3);
    bp = a_pops;
    bf = a_fires;
    a_enable = 1'b1;
    step(6);
    chk("t4_pre_m_valid", 64'(a_mvalid),     64'd1);
    chk("t4_pre_head",    64'(a_mdata),      64'h34);
    chk("t4_pre_first",   64'(a_first),      64'd1);
    chk("t4_pre_pops",    64'(a_pops - bp),  64'd2);
    chk("t4_pre_fifo",    64'(a_wp - a_rp),  64'd5);
    a_flush  = 1'b1;
    a_enable = 1'b0;
    step(1);
    a_flush = 1'b0;
    chk("t4_flush_m_valid", 64'(a_mvalid), 64'd0);
    for (int i = 0; i < 50 && a_rp != a_wp; i++) step(1);
    chk("t4_fifo_drained", 64'(a_rp == a_wp), 64'd1);
    step(3);
    chk("t4_idle_busy", 64'(a_busy),      64'd0);
    chk("t4_no_fires",  64'(a_fires - bf), 64'd0);
    chk("t4_pops",      64'(a_pops - bp),  64'd7);
    a_mready = 1'b1;
    a_enable = 1'b1;
    push_a(32'h50, 4);
    wait_a_fires(bf + 4, "t4_restart_wait");
    for (int unsigned i = 0; i < 4; i++)
      chk_a_rec(bf + i, 32'h50 + DW'(i), i == 0, i == 3);
    chk("t4_burst_count", 64'(a_bcount), 64'd6);

    // Reset while the buffer is full
    a_mready = 1'b0;
    push_a(32'h60, 4);
    step(6);
    chk("t5_pre_m_valid", 64'(a_mvalid), 64'd1);
    chk("t5_pre_head",    64'(a_mdata),  64'h60);
    rst      = 1'b1;
    a_enable = 1'b0;
    step(1);
    chk("t5_m_valid",     64'(a_mvalid), 64'd0);
    chk("t5_fifo_ready",  64'(a_fready), 64'd0);
    chk("t5_burst_count", 64'(a_bcount), 64'd0);
    chk("t5_busy",        64'(a_busy),   64'd0);
    rst = 1'b0;
    step(1);

    // Zero-latency, single-word bursts
    push_b(32'h70, 3);
    b_enable = 1'b1;
    b_mready = 1'b1;
    for (int i = 0; i < 50 && b_fires < 3; i++) step(1);
    chk("t6_wait", 64'(b_fires >= 3), 64'd1);
    for (int unsigned i = 0; i < 3; i++) begin
      r = b_rec[6'(i)];
      chk($sformatf("t6_data[%0d]", i),  64'(r[DW+1:2]), 64'(32'h70 + i));
      chk($sformatf("t6_first[%0d]", i), 64'(r[1]),      64'd1);
      chk($sformatf("t6_last[%0d]", i),  64'(r[0]),      64'd1);
    end
    chk("t6_burst_count", 64'(b_bcount), 64'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
